// File: rtl/mult_div_unit.sv
// Iterative unsigned MULTU/DIVU sharing one W+1-bit adder/subtractor; owns HI/LO.
// Result lands WIDTH+1 cycles after start; busy stalls the pipe, new starts are ignored while busy.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_nxt;
  logic [2*WIDTH:0] div_sh;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH+1:0] add_sum;
  logic             add_sub;
  logic             last;

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !flush) state_nxt = is_div ? DIV : MUL;
      MUL, DIV: begin
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = FIN;
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN) && !flush;
  end

  // One adder: MUL adds the multiplicand to the upper half, DIV subtracts the
  // divisor from the shifted remainder; carry-out set means no borrow.
  always_comb begin
    div_sh  = {acc[2*WIDTH-1:0], 1'b0};
    add_sub = (state == DIV);
    add_a   = add_sub ? div_sh[2*WIDTH:WIDTH] : acc[2*WIDTH:WIDTH];
    add_b   = {1'b0, opnd};
    add_sum = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)}
            + {{(WIDTH+1){1'b0}}, add_sub};
    acc_nxt = acc;
    if (state == MUL) begin
      if (acc[0]) acc_nxt = {add_sum[WIDTH:0], acc[WIDTH-1:0]} >> 1;
      else        acc_nxt = acc >> 1;
    end else if (state == DIV) begin
      if (add_sum[WIDTH+1]) acc_nxt = {add_sum[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};
      else                  acc_nxt = div_sh;
    end
  end

  // Product and remainder:quotient share the same layout, so FIN needs no mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            acc  <= {{(WIDTH+1){1'b0}}, dataA};
            opnd <= dataB;
            cnt  <= CW'(WIDTH);
          end
        end
        MUL, DIV: begin
          acc <= acc_nxt;
          cnt <= cnt - CW'(1);
        end
        FIN: begin
          if (!flush) begin
            hi <= acc[2*WIDTH-1:WIDTH];
            lo <= acc[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, ignored start, flush and async reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, is_div, flush;
  logic [31:0] dataA, dataB, hi, lo;
  logic        busy, done;
  int          checks = 0;
  int          failures = 0;
  int          lat, bc;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_div(is_div), .flush(flush),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic div);
    @(negedge clk);
    start = 1'b1; is_div = div; dataA = a; dataB = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // k counts negedges after the accepting edge; dist_k pulses a MULTU 2*2 start,
  // flush_k pulses flush (0 disables either).
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic div,
                     input int dist_k, input int flush_k,
                     output int lat_o, output int bc_o);
    logic [31:0] h0, l0;
    logic        moved;
    issue(a, b, div);
    h0 = hi; l0 = lo; moved = 1'b0;
    lat_o = -1; bc_o = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      bc_o++;
      if (done && lat_o < 0) lat_o = k;
      if (hi !== h0 || lo !== l0) moved = 1'b1;
      if (k == dist_k) begin start = 1'b1; is_div = 1'b0; dataA = 32'd2; dataB = 32'd2; end
      if (k == dist_k + 1) start = 1'b0;
      if (k == flush_k) flush = 1'b1;
      if (k == flush_k + 1) flush = 1'b0;
    end
    start = 1'b0; flush = 1'b0;
    check("hilo_hold_while_busy", moved, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_div = 1'b0; flush = 1'b0; dataA = '0; dataB = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(negedge clk) rst = 1'b0;

    run(32'h7, 32'h6, 1'b0, 0, 0, lat, bc);
    check("mul7x6_lat", lat, 33);
    check("mul7x6_hi", hi, 32'h0);
    check("mul7x6_lo", lo, 32'h2A);

    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, lat, bc);
    check("mulmax_busy_cycles", bc, 33);
    check("mulmax_hi", hi, 32'hFFFF_FFFE);
    check("mulmax_lo", lo, 32'h1);

    run(32'd100, 32'd7, 1'b1, 0, 0, lat, bc);
    check("div100_7_lat", lat, 33);
    check("div100_7_lo", lo, 32'hE);
    check("div100_7_hi", hi, 32'h2);

    run(32'h1234_5678, 32'h0, 1'b1, 0, 0, lat, bc);
    check("div0_lat", lat, 33);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h1234_5678);

    run(32'd5, 32'd9, 1'b1, 10, 0, lat, bc);
    check("busy_start_lat", lat, 33);
    check("busy_start_lo", lo, 32'h0);
    check("busy_start_hi", hi, 32'h5);
    run(32'd2, 32'd2, 1'b0, 0, 0, lat, bc);
    check("after_done_lo", lo, 32'h4);
    check("after_done_hi", hi, 32'h0);

    run(32'h4, 32'hC000_0001, 1'b0, 0, 0, lat, bc);
    check("preload_hi", hi, 32'h3);
    check("preload_lo", lo, 32'h4);
    run(32'd100, 32'd7, 1'b1, 0, 15, lat, bc);
    check("flush_no_done", lat < 0, 1'b1);
    check("flush_busy_cycles", bc, 15);
    check("flush_hi", hi, 32'h3);
    check("flush_lo", lo, 32'h4);

    issue(32'h7, 32'h6, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    @(negedge clk) rst = 1'b0;
    run(32'd3, 32'd5, 1'b0, 0, 0, lat, bc);
    check("postrst_lat", lat, 33);
    check("postrst_lo", lo, 32'hF);
    check("postrst_hi", hi, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
